// File: rtl/spike_aer_arbiter.sv
// ---------------------------------------------------------------------------
// spike_aer_arbiter
//
// Collects single-cycle spike pulses from an array of neurons and turns them
// into address events (AER) on a valid/ready output. Each neuron has one
// pending bit; pending neurons are granted round-robin into a single output
// register slot. Every event carries the timestep it belongs to. When the
// neuron array asks to close a timestep, the spikes pending at that moment
// are drained first (S_FLUSH), then the timestep counter advances and
// tick_ack pulses.
//
// Handshake: an event transfers on every rising edge where out_valid and
// out_ready are both 1. While out_valid=1 and out_ready=0, out_valid,
// out_addr and out_ts hold their values. tick_req is a level held by the
// requester until it sees tick_ack (a 1-cycle pulse).
//
// Ports
//   clk        in   clock, rising edge
//   rst_n      in   asynchronous active-low reset
//   in_spike   in   [N_NEURON] spike pulse per neuron, bit i = neuron i
//   tick_req   in   request to close the current timestep
//   tick_ack   out  1-cycle pulse: timestep closed, cur_ts advanced
//   out_valid  out  event valid
//   out_ready  in   downstream accepts the event
//   out_addr   out  [ADDR_W] index of the spiking neuron
//   out_ts     out  [TS_WIDTH] timestep the event belongs to
//   cur_ts     out  [TS_WIDTH] current timestep counter
//   drop_cnt   out  [DROP_W] saturating count of lost spikes
//   busy       out  any pending spike, an event in the slot, or flushing
//   dbg_state  out  FSM state (0 = S_RUN, 1 = S_FLUSH)
// ---------------------------------------------------------------------------
module spike_aer_arbiter #(
  parameter int N_NEURON = 8,
  parameter int ADDR_W   = 3,
  parameter int TS_WIDTH = 8,
  parameter int DROP_W   = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [N_NEURON-1:0] in_spike,
  input  logic                tick_req,
  output logic                tick_ack,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [ADDR_W-1:0]   out_addr,
  output logic [TS_WIDTH-1:0] out_ts,
  output logic [TS_WIDTH-1:0] cur_ts,
  output logic [DROP_W-1:0]   drop_cnt,
  output logic                busy,
  output logic                dbg_state
);

  localparam int PTR_W    = $clog2(N_NEURON);
  localparam int DROP_MAX = (1 << DROP_W) - 1;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_FLUSH = 1'b1
  } state_e;

  // Registered state
  state_e              state_q,     state_d;
  logic [N_NEURON-1:0] pending_q,   pending_d;
  logic [N_NEURON-1:0] mask_q,      mask_d;
  logic [PTR_W-1:0]    rr_ptr_q,    rr_ptr_d;
  logic                out_valid_q, out_valid_d;
  logic [ADDR_W-1:0]   out_addr_q,  out_addr_d;
  logic [TS_WIDTH-1:0] out_ts_q,    out_ts_d;
  logic [TS_WIDTH-1:0] cur_ts_q,    cur_ts_d;
  logic [DROP_W-1:0]   drop_cnt_q,  drop_cnt_d;
  logic                tick_ack_q,  tick_ack_d;

  // Arbitration signals
  logic                slot_free;
  logic [N_NEURON-1:0] eligible;
  logic                grant_vld;
  int                  grant_idx;
  logic [N_NEURON-1:0] grant_vec;
  logic                flush_done;

  // Drop accounting
  logic [N_NEURON-1:0] drop_vec;
  int                  drop_n;
  int                  drop_sum;

  // -------------------------------------------------------------------------
  // Round-robin arbitration
  // -------------------------------------------------------------------------
  // The slot can take a new event if it is empty or its event leaves now.
  assign slot_free = !out_valid_q || out_ready;

  // During a flush only spikes of the closing timestep compete; spikes that
  // arrived after the tick request wait for the next timestep.
  assign eligible = (state_q == S_FLUSH) ? (pending_q & mask_q) : pending_q;

  // Scan rr_ptr, rr_ptr+1, ... with wrap; first eligible index wins.
  always_comb begin
    int idx;
    grant_vld = 1'b0;
    grant_idx = 0;
    idx       = 0;
    for (int k = 0; k < N_NEURON; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_NEURON) idx = idx - N_NEURON;
      if (slot_free && !grant_vld && eligible[idx]) begin
        grant_vld = 1'b1;
        grant_idx = idx;
      end
    end
  end

  always_comb begin
    grant_vec = '0;
    for (int i = 0; i < N_NEURON; i++) begin
      grant_vec[i] = grant_vld && (grant_idx == i);
    end
  end

  // Flush is complete once nothing of the old timestep is pending and the
  // slot holds no un-accepted event (slot_free with no grant).
  assign flush_done = slot_free && (eligible == '0);

  // -------------------------------------------------------------------------
  // Drops: a spike on a neuron that is already pending and not being granted
  // this cycle is lost. A granted neuron that spikes again simply stays set.
  // -------------------------------------------------------------------------
  assign drop_vec = in_spike & pending_q & ~grant_vec;

  always_comb begin
    drop_n = 0;
    for (int i = 0; i < N_NEURON; i++) begin
      if (drop_vec[i]) drop_n = drop_n + 1;
    end
    drop_sum = int'(drop_cnt_q) + drop_n;
    if (drop_sum > DROP_MAX) begin
      drop_cnt_d = DROP_W'(DROP_MAX);
    end else begin
      drop_cnt_d = DROP_W'(drop_sum);
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    pending_d   = (pending_q & ~grant_vec) | in_spike;
    mask_d      = mask_q;
    state_d     = state_q;
    cur_ts_d    = cur_ts_q;
    tick_ack_d  = 1'b0;
    rr_ptr_d    = rr_ptr_q;
    out_valid_d = out_valid_q;
    out_addr_d  = out_addr_q;
    out_ts_d    = out_ts_q;

    case (state_q)
      S_RUN: begin
        // Snapshot includes spikes captured on this same edge.
        if (tick_req) begin
          mask_d  = pending_d;
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        // A granted neuron leaves the mask even if it spikes again now; the
        // new spike belongs to the next timestep.
        mask_d = mask_q & ~grant_vec;
        if (flush_done) begin
          cur_ts_d   = cur_ts_q + TS_WIDTH'(1);
          tick_ack_d = 1'b1;
          mask_d     = '0;
          state_d    = S_RUN;
        end
      end
      default: begin
        state_d = S_RUN;
      end
    endcase

    if (slot_free) begin
      if (grant_vld) begin
        out_valid_d = 1'b1;
        out_addr_d  = ADDR_W'(grant_idx);
        out_ts_d    = cur_ts_q;
        rr_ptr_d    = (grant_idx >= N_NEURON - 1) ? '0 : PTR_W'(grant_idx + 1);
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  // -------------------------------------------------------------------------
  // State registers (FSM and its registered outputs)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      pending_q   <= '0;
      mask_q      <= '0;
      rr_ptr_q    <= '0;
      out_valid_q <= 1'b0;
      out_addr_q  <= '0;
      out_ts_q    <= '0;
      cur_ts_q    <= '0;
      drop_cnt_q  <= '0;
      tick_ack_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      pending_q   <= pending_d;
      mask_q      <= mask_d;
      rr_ptr_q    <= rr_ptr_d;
      out_valid_q <= out_valid_d;
      out_addr_q  <= out_addr_d;
      out_ts_q    <= out_ts_d;
      cur_ts_q    <= cur_ts_d;
      drop_cnt_q  <= drop_cnt_d;
      tick_ack_q  <= tick_ack_d;
    end
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign tick_ack  = tick_ack_q;
  assign out_valid = out_valid_q;
  assign out_addr  = out_addr_q;
  assign out_ts    = out_ts_q;
  assign cur_ts    = cur_ts_q;
  assign drop_cnt  = drop_cnt_q;
  assign busy      = (|pending_q) || out_valid_q || (state_q == S_FLUSH);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_spike_aer_arbiter.sv
// ---------------------------------------------------------------------------
// tb_spike_aer_arbiter
//
// Directed scenarios plus a randomized run for spike_aer_arbiter. A
// behavioural model (neuron set + event slot + timestep counter) predicts
// every registered output each cycle; outputs are sampled on the falling
// edge. Directed scenarios additionally check hand-computed constants.
// ---------------------------------------------------------------------------
module tb_spike_aer_arbiter;

  localparam int N  = 8;
  localparam int AW = 3;
  localparam int TW = 8;
  localparam int DW = 8;

  // -------------------------------------------------------------------------
  // Clock / reset
  // -------------------------------------------------------------------------
  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  in_spike = '0;
  logic          tick_req = 1'b0;
  logic          out_ready = 1'b0;
  logic          tick_ack;
  logic          out_valid;
  logic [AW-1:0] out_addr;
  logic [TW-1:0] out_ts;
  logic [TW-1:0] cur_ts;
  logic [DW-1:0] drop_cnt;
  logic          busy;
  logic          dbg_state;

  always #5 clk = ~clk;

  spike_aer_arbiter #(
    .N_NEURON(N), .ADDR_W(AW), .TS_WIDTH(TW), .DROP_W(DW)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_spike  (in_spike),
    .tick_req  (tick_req),
    .tick_ack  (tick_ack),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_ts    (out_ts),
    .cur_ts    (cur_ts),
    .drop_cnt  (drop_cnt),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  // -------------------------------------------------------------------------
  // Scoreboard counters and check task
  // -------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // -------------------------------------------------------------------------
  // Behavioural model
  //   m_pend  : neurons with a spike waiting for the output
  //   m_close : neurons whose waiting spike belongs to the timestep being closed
  //   m_next  : neuron index where the next round-robin search starts
  // -------------------------------------------------------------------------
  bit [N-1:0] m_pend;
  bit [N-1:0] m_close;
  int         m_next;
  bit         m_flush;
  bit         m_valid;
  int         m_addr;
  int         m_ts;
  int         m_cur;
  int         m_drop;
  bit         m_ack;

  task automatic model_reset();
    m_pend = '0; m_close = '0; m_next = 0; m_flush = 0;
    m_valid = 0; m_addr = 0; m_ts = 0; m_cur = 0; m_drop = 0; m_ack = 0;
  endtask

  task automatic model_step(input logic [N-1:0] spk, input logic rdy, input logic treq);
    bit         can_load;
    int         win;
    int         lost;
    int         ts_now;
    bit [N-1:0] after;
    can_load = !m_valid || rdy;
    win = -1;
    if (can_load) begin
      for (int k = 0; k < N; k++) begin
        int n;
        n = (m_next + k) % N;
        if (win < 0 && m_pend[n] && (!m_flush || m_close[n])) win = n;
      end
    end
    lost = 0;
    for (int i = 0; i < N; i++) begin
      if (spk[i] && m_pend[i] && i != win) lost++;
      after[i] = (m_pend[i] && i != win) || spk[i];
    end
    ts_now = m_cur;
    m_ack = 0;
    if (m_flush) begin
      if (win >= 0) m_close[win] = 0;
      if (can_load && win < 0) begin
        m_cur = (m_cur + 1) % 256;
        m_ack = 1;
        m_close = '0;
        m_flush = 0;
      end
    end else if (treq) begin
      m_close = after;
      m_flush = 1;
    end
    if (can_load) begin
      if (win >= 0) begin
        m_valid = 1; m_addr = win; m_ts = ts_now; m_next = (win + 1) % N;
      end else begin
        m_valid = 0;
      end
    end
    m_pend = after;
    m_drop = (m_drop + lost > 255) ? 255 : m_drop + lost;
  endtask

  task automatic compare_all();
    check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
    check("out_addr", {29'd0, out_addr}, m_addr);
    check("out_ts", {24'd0, out_ts}, m_ts);
    check("cur_ts", {24'd0, cur_ts}, m_cur);
    check("drop_cnt", {24'd0, drop_cnt}, m_drop);
    check("tick_ack", {31'd0, tick_ack}, {31'd0, m_ack});
    check("busy", {31'd0, busy}, {31'd0, (|m_pend) || m_valid || m_flush});
    check("state", {31'd0, dbg_state}, {31'd0, m_flush});
  endtask

  // -------------------------------------------------------------------------
  // Driver tasks (inputs change just after the falling edge)
  // -------------------------------------------------------------------------
  task automatic step(input logic [N-1:0] spk, input logic rdy, input logic treq);
    in_spike  = spk;
    out_ready = rdy;
    tick_req  = treq;
    model_step(spk, rdy, treq);
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_spike = '0; tick_req = 1'b0; out_ready = 1'b0;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // -------------------------------------------------------------------------
  // Stimulus
  // -------------------------------------------------------------------------
  initial begin
    logic [N-1:0] spk;
    logic         rdy;
    logic         treq;

    // 1: single spike on neuron 2 appears two cycles later, for one cycle
    do_reset();
    step(8'h04, 1'b1, 1'b0);
    check("t1_not_yet", {31'd0, out_valid}, 32'd0);
    step(8'h00, 1'b1, 1'b0);
    check("t1_valid", {31'd0, out_valid}, 32'd1);
    check("t1_addr", {29'd0, out_addr}, 32'd2);
    check("t1_ts", {24'd0, out_ts}, 32'd0);
    step(8'h00, 1'b1, 1'b0);
    check("t1_single", {31'd0, out_valid}, 32'd0);

    // 2: all neurons spike once -> addresses 0..7 back to back, then 3
    do_reset();
    step(8'hFF, 1'b1, 1'b0);
    for (int k = 0; k < N; k++) begin
      step(8'h00, 1'b1, 1'b0);
      check("t2_valid", {31'd0, out_valid}, 32'd1);
      check("t2_addr", {29'd0, out_addr}, k);
    end
    step(8'h08, 1'b1, 1'b0);
    check("t2_gap", {31'd0, out_valid}, 32'd0);
    step(8'h00, 1'b1, 1'b0);
    check("t2_after_addr", {29'd0, out_addr}, 32'd3);
    check("t2_after_valid", {31'd0, out_valid}, 32'd1);

    // 3: stalled output, neuron 0 spikes three times -> one drop
    do_reset();
    step(8'h01, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    step(8'h01, 1'b0, 1'b0);
    step(8'h01, 1'b0, 1'b0);
    check("t3_hold_valid", {31'd0, out_valid}, 32'd1);
    check("t3_hold_addr", {29'd0, out_addr}, 32'd0);
    check("t3_drop", {24'd0, drop_cnt}, 32'd1);
    step(8'h00, 1'b1, 1'b0);
    check("t3_second_valid", {31'd0, out_valid}, 32'd1);
    check("t3_second_addr", {29'd0, out_addr}, 32'd0);
    step(8'h00, 1'b1, 1'b0);
    check("t3_empty", {31'd0, out_valid}, 32'd0);

    // 4: flush of {1,5}, spike on 6 during flush goes to next timestep
    do_reset();
    step(8'h22, 1'b1, 1'b1);
    step(8'h00, 1'b1, 1'b1);
    check("t4_ev1_addr", {29'd0, out_addr}, 32'd1);
    check("t4_ev1_ts", {24'd0, out_ts}, 32'd0);
    step(8'h40, 1'b1, 1'b1);
    check("t4_ev5_addr", {29'd0, out_addr}, 32'd5);
    check("t4_ev5_ts", {24'd0, out_ts}, 32'd0);
    step(8'h00, 1'b1, 1'b1);
    check("t4_ack", {31'd0, tick_ack}, 32'd1);
    check("t4_cur_ts", {24'd0, cur_ts}, 32'd1);
    step(8'h00, 1'b1, 1'b0);
    check("t4_ev6_valid", {31'd0, out_valid}, 32'd1);
    check("t4_ev6_addr", {29'd0, out_addr}, 32'd6);
    check("t4_ev6_ts", {24'd0, out_ts}, 32'd1);
    check("t4_ack_pulse", {31'd0, tick_ack}, 32'd0);

    // 5: timestep wrap 255 -> 0, drop counter saturation
    do_reset();
    for (int k = 0; k < 255; k++) begin
      step(8'h00, 1'b1, 1'b1);
      step(8'h00, 1'b1, 1'b0);
    end
    check("t5_ts255", {24'd0, cur_ts}, 32'd255);
    step(8'h00, 1'b1, 1'b1);
    step(8'h00, 1'b1, 1'b0);
    check("t5_wrap_ack", {31'd0, tick_ack}, 32'd1);
    check("t5_wrap_ts", {24'd0, cur_ts}, 32'd0);
    for (int k = 0; k < 40; k++) step(8'hFF, 1'b0, 1'b0);
    check("t5_drop_sat", {24'd0, drop_cnt}, 32'd255);
    step(8'hFF, 1'b0, 1'b0);
    check("t5_drop_stay", {24'd0, drop_cnt}, 32'd255);

    // 6: asynchronous reset with an event queued and spikes pending
    do_reset();
    step(8'hFF, 1'b0, 1'b0);
    step(8'h00, 1'b0, 1'b0);
    check("t6_pre_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    check("t6_busy0", {31'd0, busy}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      step(8'h00, 1'b1, 1'b0);
      check("t6_no_stale", {31'd0, out_valid}, 32'd0);
    end

    // Randomized run: sparse spikes, random backpressure, tick handshakes
    do_reset();
    treq = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) spk[i] = ($urandom_range(0, 9) == 0);
      if ((c / 500) % 2 == 1) spk = spk | {N{($urandom_range(0, 3) == 0)}};
      rdy = ($urandom_range(0, 3) != 0);
      if (m_ack) treq = 1'b0;
      else if (!treq && $urandom_range(0, 15) == 0) treq = 1'b1;
      step(spk, rdy, treq);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
